// File: rtl/core_pkg.sv
// Shared fetch-path types and constants.
package core_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; flush wins over push and pop.
module sync_fifo
  import core_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  T                             data_i,
  output T                             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];
  assign do_push = push_i && !flush_i && !full_o;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prefetch_fetch.sv
// IF stage: pipelined imem requests with credit control, prefetch FIFO and IF/ID register.
module prefetch_fetch
  import core_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEF
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               stall_i,
  input  logic               new_pc_i,
  input  logic [31:0]        pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o,
  output logic               req_o,
  output logic [31:0]        raddr_o,
  input  logic               gnt_i,
  input  logic               rvalid_i,
  input  logic [INSTR_W-1:0] rdata_i
);

  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_next;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target_pc;
  logic          hs;
  logic          resp_keep;
  logic          advance;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  resp_entry;

  assign target_pc  = align_pc(pc_i);
  assign credit     = {1'b0, fifo_count} + {1'b0, outstanding};
  assign req_o      = rstn_i && !new_pc_i && (outstanding < CW'(MAX_OUTSTANDING))
                      && (credit < (CW+1)'(DEPTH));
  assign raddr_o    = fetch_pc;
  assign hs         = req_o && gnt_i;
  // A response landing in the redirect cycle still belongs to the old stream.
  assign resp_keep  = rvalid_i && (discard == '0) && !new_pc_i;
  assign advance    = !new_pc_i && !stall_i;
  assign fifo_pop   = advance && !fifo_empty;
  assign fifo_push  = resp_keep && !(advance && fifo_empty);
  assign resp_entry = '{pc: resp_pc, instr: rdata_i};

  always_comb begin
    out_next = outstanding;
    unique case ({hs, rvalid_i})
      2'b10:   out_next = outstanding + 1'b1;
      2'b01:   out_next = outstanding - 1'b1;
      default: out_next = outstanding;
    endcase
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (new_pc_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (resp_entry),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Request/response bookkeeping; discard counts in-flight responses of a dead stream.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;
      if (new_pc_i) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        discard  <= out_next;
      end else begin
        if (hs)                         fetch_pc <= fetch_pc + 32'd4;
        if (resp_keep)                  resp_pc  <= resp_pc + 32'd4;
        if (rvalid_i && discard != '0)  discard  <= discard - 1'b1;
      end
    end
  end

  // IF/ID register: flush, then stall, then FIFO head, then bypass.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      valid_o <= 1'b0;
      instr_o <= '0;
      pc_o    <= '0;
    end else if (new_pc_i) begin
      valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (!fifo_empty) begin
        valid_o <= 1'b1;
        instr_o <= head.instr;
        pc_o    <= head.pc;
      end else if (resp_keep) begin
        valid_o <= 1'b1;
        instr_o <= rdata_i;
        pc_o    <= resp_pc;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

  a_out_max:  assert property (@(posedge clk_i) disable iff (!rstn_i)
                               outstanding <= CW'(MAX_OUTSTANDING));
  a_no_spur:  assert property (@(posedge clk_i) disable iff (!rstn_i)
                               !(rvalid_i && outstanding == '0));
  a_no_ovf:   assert property (@(posedge clk_i) disable iff (!rstn_i)
                               !(fifo_push && fifo_full));
  a_disc_le:  assert property (@(posedge clk_i) disable iff (!rstn_i)
                               discard <= outstanding);

endmodule
